uart_rx_parametrizado: RTL and testbench



---
 rtl/uart_rx_parametrizado.sv | 143 ++++++++++++++
 tb/tb_uart_rx_parametrizado.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parametrizado.sv
// Parametrised UART receiver: LSB-first words, optional parity, 1 or 2 stop bits, one-cycle strobe.
// Define UART_RX_VOTO_MAIORIA_EN for a 2-of-3 majority vote around every sample point.
module uart_rx_parametrizado #(
  parameter int CLOCKS_POR_BIT = 5209,
  parameter int DATA_BITS      = 8,
  parameter int PARIDADE       = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bitSerialAtual,
  output logic                 bitsEstaoRecebidos,
  output logic [DATA_BITS-1:0] byteCompleto,
  output logic                 erroParidade,
  output logic                 erroQuadro,
  output logic                 ocupado
);
  localparam int CW = $clog2(CLOCKS_POR_BIT);

  localparam logic [2:0] OCIOSO         = 3'd0;
  localparam logic [2:0] INICIO         = 3'd1;
  localparam logic [2:0] DADOS          = 3'd2;
  localparam logic [2:0] CHECA_PARIDADE = 3'd3;
  localparam logic [2:0] PARADA         = 3'd4;

  localparam logic [CW-1:0] ULTIMA = CW'(CLOCKS_POR_BIT - 1);
`ifdef UART_RX_VOTO_MAIORIA_EN
  // The vote needs one sample past the nominal point, so every decision lands a cycle later.
  localparam logic [CW-1:0] MEIO = CW'((CLOCKS_POR_BIT - 1) / 2 + 1);
`else
  localparam logic [CW-1:0] MEIO = CW'((CLOCKS_POR_BIT - 1) / 2);
`endif
  localparam logic [4:0] ULTIMO_DADO   = 5'(DATA_BITS - 1);
  localparam logic [4:0] ULTIMA_PARADA = 5'(STOP_BITS - 1);

  logic                 sync1, sync2, amostra;
  logic [2:0]           estado;
  logic [CW-1:0]        contador;
  logic [4:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic                 xorDados, erroParAcc, quadroAcc, rearmar;

`ifdef UART_RX_VOTO_MAIORIA_EN
  logic [1:0] historico;

  always_ff @(posedge clock) begin
    if (reset) historico <= 2'b11;
    else       historico <= {historico[0], sync2};
  end

  assign amostra = (historico[1] & historico[0]) | (historico[1] & sync2) | (historico[0] & sync2);
`else
  assign amostra = sync2;
`endif

  assign ocupado = (estado != OCIOSO);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1              <= 1'b1;
      sync2              <= 1'b1;
      estado             <= OCIOSO;
      contador           <= '0;
      idx                <= '0;
      shift              <= '0;
      xorDados           <= 1'b0;
      erroParAcc         <= 1'b0;
      quadroAcc          <= 1'b0;
      rearmar            <= 1'b0;
      bitsEstaoRecebidos <= 1'b0;
      byteCompleto       <= '0;
      erroParidade       <= 1'b0;
      erroQuadro         <= 1'b0;
    end else begin
      sync1              <= bitSerialAtual;
      sync2              <= sync1;
      bitsEstaoRecebidos <= 1'b0;
      case (estado)
        OCIOSO: begin
          contador   <= '0;
          idx        <= '0;
          xorDados   <= 1'b0;
          erroParAcc <= 1'b0;
          quadroAcc  <= 1'b0;
          // After a frame that ended on a low line (break), wait for the line to go high first.
          if (rearmar)     rearmar <= ~sync2;
          else if (!sync2) estado  <= INICIO;
        end
        INICIO: begin
          if (contador == MEIO) begin
            contador <= '0;
            estado   <= amostra ? OCIOSO : DADOS;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        DADOS: begin
          if (contador == ULTIMA) begin
            contador <= '0;
            shift    <= {amostra, shift[DATA_BITS-1:1]};
            xorDados <= xorDados ^ amostra;
            if (idx == ULTIMO_DADO) begin
              idx    <= '0;
              estado <= (PARIDADE != 0) ? CHECA_PARIDADE : PARADA;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            contador <= contador + 1'b1;
          end
        end
        CHECA_PARIDADE: begin
          if (contador == ULTIMA) begin
            contador   <= '0;
            erroParAcc <= (PARIDADE == 1) ? ~(xorDados ^ amostra) : (xorDados ^ amostra);
            estado     <= PARADA;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        PARADA: begin
          if (contador == ULTIMA) begin
            contador <= '0;
            if (idx == ULTIMA_PARADA) begin
              byteCompleto       <= shift;
              erroParidade       <= erroParAcc;
              erroQuadro         <= quadroAcc | ~amostra;
              bitsEstaoRecebidos <= 1'b1;
              rearmar            <= ~amostra;
              estado             <= OCIOSO;
            end else begin
              quadroAcc <= quadroAcc | ~amostra;
              idx       <= idx + 1'b1;
            end
          end else begin
            contador <= contador + 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_parametrizado.sv
// Bench for uart_rx_parametrizado: four receiver configurations, each on its own serial line,
// frames built bit by bit and checked against a word/flag/latency model derived from the frame format.
module tb_uart_rx_parametrizado;
  localparam int C = 16;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_VOTO_MAIORIA_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    int          inst;
    logic [15:0] data;
    logic        ep;
    logic        eq;
    int          cyc;
  } cap_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  linha = 4'hF;
  logic [3:0]  strobe, ePar, eQua, ocup;
  logic [7:0]  dado0, dado1, dado3;
  logic [15:0] dado2;
  logic [15:0] dadoVec [4];
  int          cyc = 0;
  int          vectorCount = 0;
  int          miscompareCount = 0;
  cap_t        capQ [$];
  logic [17:0] expQ [$];

  assign dadoVec[0] = {8'h00, dado0};
  assign dadoVec[1] = {8'h00, dado1};
  assign dadoVec[2] = dado2;
  assign dadoVec[3] = {8'h00, dado3};

  // Instance 0: 8N1. 1: 8E1. 2: 16N1. 3: 8O2.
  uart_rx_parametrizado #(.CLOCKS_POR_BIT(C), .DATA_BITS(8), .PARIDADE(0), .STOP_BITS(1)) dut8n1 (
    .clock(clock), .reset(reset), .bitSerialAtual(linha[0]), .bitsEstaoRecebidos(strobe[0]),
    .byteCompleto(dado0), .erroParidade(ePar[0]), .erroQuadro(eQua[0]), .ocupado(ocup[0]));
  uart_rx_parametrizado #(.CLOCKS_POR_BIT(C), .DATA_BITS(8), .PARIDADE(2), .STOP_BITS(1)) dut8e1 (
    .clock(clock), .reset(reset), .bitSerialAtual(linha[1]), .bitsEstaoRecebidos(strobe[1]),
    .byteCompleto(dado1), .erroParidade(ePar[1]), .erroQuadro(eQua[1]), .ocupado(ocup[1]));
  uart_rx_parametrizado #(.CLOCKS_POR_BIT(C), .DATA_BITS(16), .PARIDADE(0), .STOP_BITS(1)) dut16n1 (
    .clock(clock), .reset(reset), .bitSerialAtual(linha[2]), .bitsEstaoRecebidos(strobe[2]),
    .byteCompleto(dado2), .erroParidade(ePar[2]), .erroQuadro(eQua[2]), .ocupado(ocup[2]));
  uart_rx_parametrizado #(.CLOCKS_POR_BIT(C), .DATA_BITS(8), .PARIDADE(1), .STOP_BITS(2)) dut8o2 (
    .clock(clock), .reset(reset), .bitSerialAtual(linha[3]), .bitsEstaoRecebidos(strobe[3]),
    .byteCompleto(dado3), .erroParidade(ePar[3]), .erroQuadro(eQua[3]), .ocupado(ocup[3]));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (strobe[i] === 1'b1)
        capQ.push_back('{inst: i, data: dadoVec[i], ep: ePar[i], eq: eQua[i], cyc: cyc});
    end
  end

  function automatic int nData(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int nPar(input int i);
    return (i == 1) ? 2 : ((i == 3) ? 1 : 0);
  endfunction

  function automatic int nStop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Cycles from the negedge the start bit is driven to the edge after which the strobe is high.
  function automatic int latencia(input int inst);
    return 4 + H + (nData(inst) + ((nPar(inst) != 0) ? 1 : 0) + nStop(inst)) * C + EXTRA;
  endfunction

  // Expected {word, parity error, framing error} for a frame sent with the given fields.
  function automatic logic [17:0] modelo(input int inst, input logic [15:0] d, input logic pb,
                                         input logic [1:0] st);
    logic [15:0] m;
    logic        x, ep, eq;
    m  = d & 16'((32'h1 << nData(inst)) - 1);
    x  = (^m) ^ pb;
    if (nPar(inst) == 0)      ep = 1'b0;
    else if (nPar(inst) == 1) ep = ~x;
    else                      ep = x;
    eq = (nStop(inst) == 2) ? ~(st[0] & st[1]) : ~st[0];
    return {m, ep, eq};
  endfunction

  // Drives one whole frame starting at a negedge; optionally inverts one cycle at each mid-bit.
  task automatic sendFrame(input int inst, input logic [15:0] d, input logic pb, input logic [1:0] st,
                           input bit inject, output int startCyc);
    logic cells [$];
    cells.push_back(1'b0);
    for (int i = 0; i < nData(inst); i++) cells.push_back(d[i]);
    if (nPar(inst) != 0) cells.push_back(pb);
    for (int i = 0; i < nStop(inst); i++) cells.push_back(st[i]);
    startCyc = cyc;
    foreach (cells[k]) begin
      for (int i = 0; i < C; i++) begin
        linha[inst] = cells[k] ^ ((inject && i == H + 1) ? 1'b1 : 1'b0);
        @(negedge clock);
      end
    end
    linha[inst] = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      vectorCount++;
      if ({strobe[i], ePar[i], eQua[i], ocup[i]} !== 4'b0000) begin
        miscompareCount++;
        $display("FAIL reset_flags[%0d]: got %b want 0000", i, {strobe[i], ePar[i], eQua[i], ocup[i]});
      end
      vectorCount++;
      if (dadoVec[i] !== 16'h0000) begin
        miscompareCount++;
        $display("FAIL reset_data[%0d]: got %h want 0000", i, dadoVec[i]);
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_8n1();
    int          s;
    cap_t        c;
    logic [15:0] d;
    capQ.delete();
    for (int n = 0; n < 7; n++) begin
      d = (n == 0) ? 16'h00A5 : 16'($urandom_range(0, 255));
      sendFrame(0, d, 1'b0, 2'b11, 1'b0, s);
      expQ.push_back(modelo(0, d, 1'b0, 2'b11));
      vectorCount++;
      if (capQ.size() != 1) begin
        miscompareCount++;
        $display("FAIL 8n1_strobes: got %0d want 1 (word %h)", capQ.size(), d);
      end else begin
        c = capQ.pop_front();
        vectorCount++;
        if ({c.data, c.ep, c.eq} !== expQ[0]) begin
          miscompareCount++;
          $display("FAIL 8n1_word: got %h ep%b eq%b want %h ep%b eq%b", c.data, c.ep, c.eq,
                   expQ[0][17:2], expQ[0][1], expQ[0][0]);
        end
        vectorCount++;
        if (c.cyc != s + latencia(0)) begin
          miscompareCount++;
          $display("FAIL 8n1_latency: got %0d want %0d", c.cyc - s, latencia(0));
        end
      end
      void'(expQ.pop_front());
      capQ.delete();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  task automatic test_paridade();
    int          s, inst, gap;
    cap_t        c;
    logic [15:0] d;
    logic        pb;
    logic [1:0]  st;
    capQ.delete();
    for (int n = 0; n < 12; n++) begin
      inst = (n < 2 || n % 2 == 0) ? 1 : 3;
      d    = (n < 2) ? 16'h0007 : 16'($urandom_range(0, 255));
      pb   = (n < 2) ? n[0] : 1'($urandom_range(0, 1));
      st   = (n < 2 || $urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (inst == 1) st[1] = 1'b1;
      sendFrame(inst, d, pb, st, 1'b0, s);
      expQ.push_back(modelo(inst, d, pb, st));
      vectorCount++;
      if (capQ.size() != 1) begin
        miscompareCount++;
        $display("FAIL par_strobes[%0d]: got %0d want 1", inst, capQ.size());
      end else begin
        c = capQ.pop_front();
        vectorCount++;
        if ({c.data, c.ep, c.eq} !== expQ[0]) begin
          miscompareCount++;
          $display("FAIL par_word[%0d]: got %h ep%b eq%b want %h ep%b eq%b", inst, c.data, c.ep, c.eq,
                   expQ[0][17:2], expQ[0][1], expQ[0][0]);
        end
        vectorCount++;
        if (c.cyc != s + latencia(inst)) begin
          miscompareCount++;
          $display("FAIL par_latency[%0d]: got %0d want %0d", inst, c.cyc - s, latencia(inst));
        end
      end
      void'(expQ.pop_front());
      capQ.delete();
      // A low final stop bit leaves the receiver waiting for an idle-high line.
      gap = (st[nStop(inst) - 1] == 1'b0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
      repeat (gap) @(negedge clock);
    end
  endtask

  task automatic test_quadro();
    int          s;
    cap_t        c;
    logic [15:0] dv [2];
    logic [1:0]  sv [2];
    dv[0] = 16'h003C; sv[0] = 2'b10;
    dv[1] = 16'h0055; sv[1] = 2'b11;
    capQ.delete();
    for (int n = 0; n < 2; n++) begin
      sendFrame(0, dv[n], 1'b0, sv[n], 1'b0, s);
      expQ.push_back(modelo(0, dv[n], 1'b0, sv[n]));
      vectorCount++;
      if (capQ.size() != 1) begin
        miscompareCount++;
        $display("FAIL quadro_strobes: got %0d want 1", capQ.size());
      end else begin
        c = capQ.pop_front();
        vectorCount++;
        if ({c.data, c.ep, c.eq} !== expQ[0]) begin
          miscompareCount++;
          $display("FAIL quadro_word: got %h ep%b eq%b want %h ep%b eq%b", c.data, c.ep, c.eq,
                   expQ[0][17:2], expQ[0][1], expQ[0][0]);
        end
      end
      void'(expQ.pop_front());
      capQ.delete();
      repeat (2 * C) @(negedge clock);
    end
  endtask

  task automatic test_glitch();
    int   s;
    cap_t c;
    capQ.delete();
    linha[0] = 1'b0;
    repeat (4) @(negedge clock);
    linha[0] = 1'b1;
    vectorCount++;
    if (ocup[0] !== 1'b1) begin
      miscompareCount++;
      $display("FAIL glitch_busy: got %b want 1", ocup[0]);
    end
    repeat (8) @(negedge clock);
    vectorCount++;
    if (ocup[0] !== 1'b0) begin
      miscompareCount++;
      $display("FAIL glitch_idle: got %b want 0", ocup[0]);
    end
    repeat (3 * C) @(negedge clock);
    vectorCount++;
    if (capQ.size() != 0) begin
      miscompareCount++;
      $display("FAIL glitch_nostrobe: got %0d want 0", capQ.size());
    end
    capQ.delete();
    sendFrame(0, 16'h0081, 1'b0, 2'b11, 1'b0, s);
    vectorCount++;
    if (capQ.size() != 1) begin
      miscompareCount++;
      $display("FAIL glitch_after: got %0d strobes want 1", capQ.size());
    end else begin
      c = capQ.pop_front();
      vectorCount++;
      if ({c.data, c.ep, c.eq} !== modelo(0, 16'h0081, 1'b0, 2'b11)) begin
        miscompareCount++;
        $display("FAIL glitch_word: got %h ep%b eq%b want 0081 ep0 eq0", c.data, c.ep, c.eq);
      end
    end
    capQ.delete();
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset_meio();
    int          s;
    cap_t        c;
    logic [7:0]  d;
    d = 8'hF0;
    capQ.delete();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < C; i++) begin
        linha[0] = (k == 0) ? 1'b0 : d[k - 1];
        @(negedge clock);
      end
    end
    linha[0] = d[3];
    repeat (H) @(negedge clock);
    vectorCount++;
    if (ocup[0] !== 1'b1) begin
      miscompareCount++;
      $display("FAIL rstmid_busy: got %b want 1", ocup[0]);
    end
    reset = 1'b1;
    @(negedge clock);
    vectorCount++;
    if ({dado0, strobe[0], ePar[0], eQua[0], ocup[0]} !== 12'h000) begin
      miscompareCount++;
      $display("FAIL rstmid_outputs0: got %h want 000", {dado0, strobe[0], ePar[0], eQua[0], ocup[0]});
    end
    vectorCount++;
    if ({dado3, ePar[3], eQua[3]} !== 10'h000) begin
      miscompareCount++;
      $display("FAIL rstmid_outputs3: got %h want 000", {dado3, ePar[3], eQua[3]});
    end
    reset = 1'b0;
    linha[0] = 1'b1;
    repeat (12 * C) @(negedge clock);
    vectorCount++;
    if (capQ.size() != 0) begin
      miscompareCount++;
      $display("FAIL rstmid_nostrobe: got %0d want 0", capQ.size());
    end
    capQ.delete();
    sendFrame(0, 16'h003C, 1'b0, 2'b11, 1'b0, s);
    vectorCount++;
    if (capQ.size() != 1) begin
      miscompareCount++;
      $display("FAIL rstmid_after: got %0d strobes want 1", capQ.size());
    end else begin
      c = capQ.pop_front();
      vectorCount++;
      if ({c.data, c.ep, c.eq} !== modelo(0, 16'h003C, 1'b0, 2'b11)) begin
        miscompareCount++;
        $display("FAIL rstmid_word: got %h ep%b eq%b want 003c ep0 eq0", c.data, c.ep, c.eq);
      end
      vectorCount++;
      if (c.cyc != s + latencia(0)) begin
        miscompareCount++;
        $display("FAIL rstmid_latency: got %0d want %0d", c.cyc - s, latencia(0));
      end
    end
    capQ.delete();
    repeat (4) @(negedge clock);
  endtask

  task automatic test_quebra();
    int   s;
    cap_t c;
    capQ.delete();
    s = cyc;
    linha[0] = 1'b0;
    repeat (30 * C) @(negedge clock);
    vectorCount++;
    if (ocup[0] !== 1'b0) begin
      miscompareCount++;
      $display("FAIL break_rearm: got busy %b want 0", ocup[0]);
    end
    vectorCount++;
    if (capQ.size() != 1) begin
      miscompareCount++;
      $display("FAIL break_strobes: got %0d want 1", capQ.size());
    end else begin
      c = capQ.pop_front();
      vectorCount++;
      if ({c.data, c.ep, c.eq} !== modelo(0, 16'h0000, 1'b0, 2'b00)) begin
        miscompareCount++;
        $display("FAIL break_word: got %h ep%b eq%b want 0000 ep0 eq1", c.data, c.ep, c.eq);
      end
      vectorCount++;
      if (c.cyc != s + latencia(0)) begin
        miscompareCount++;
        $display("FAIL break_latency: got %0d want %0d", c.cyc - s, latencia(0));
      end
    end
    linha[0] = 1'b1;
    capQ.delete();
    repeat (2 * C) @(negedge clock);
    sendFrame(0, 16'h0055, 1'b0, 2'b11, 1'b0, s);
    vectorCount++;
    if (capQ.size() != 1) begin
      miscompareCount++;
      $display("FAIL break_after: got %0d strobes want 1", capQ.size());
    end else begin
      c = capQ.pop_front();
      vectorCount++;
      if ({c.data, c.ep, c.eq} !== modelo(0, 16'h0055, 1'b0, 2'b11)) begin
        miscompareCount++;
        $display("FAIL break_after_word: got %h ep%b eq%b want 0055 ep0 eq0", c.data, c.ep, c.eq);
      end
    end
    capQ.delete();
    repeat (4) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int          s;
    int          passes;
    cap_t        c;
    logic [15:0] d;
    bit          inj;
`ifdef UART_RX_VOTO_MAIORIA_EN
    passes = 2;
`else
    passes = 1;
`endif
    capQ.delete();
    for (int p = 0; p < passes; p++) begin
      inj = (p == 1);
      for (int n = 0; n < 5; n++) begin
        d = (n == 0) ? 16'h1234 : ((n == 1) ? 16'hBEEF : 16'($urandom_range(0, 65535)));
        sendFrame(2, d, 1'b0, 2'b11, inj, s);
        vectorCount++;
        if (capQ.size() != 1) begin
          miscompareCount++;
          $display("FAIL b2b_strobes: got %0d want 1 (word %h inj %0d)", capQ.size(), d, inj);
        end else begin
          c = capQ.pop_front();
          vectorCount++;
          if ({c.data, c.ep, c.eq} !== modelo(2, d, 1'b0, 2'b11)) begin
            miscompareCount++;
            $display("FAIL b2b_word: got %h ep%b eq%b want %h ep0 eq0 (inj %0d)", c.data, c.ep, c.eq, d, inj);
          end
          vectorCount++;
          if (c.cyc != s + latencia(2)) begin
            miscompareCount++;
            $display("FAIL b2b_latency: got %0d want %0d", c.cyc - s, latencia(2));
          end
        end
        capQ.delete();
      end
      repeat (2 * C) @(negedge clock);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_8n1();
    test_paridade();
    test_quadro();
    test_glitch();
    test_reset_meio();
    test_quebra();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end
endmodule
